// File: rtl/sev_seg_pkg.sv
// Shared constants for the seven-segment scan driver.
// Provides the hex-to-segment table (bit i = segment SEG_BIT_*), the segment
// bit positions within {g,f,e,d,c,b,a}, and a width helper for counters.
package sev_seg_pkg;

    localparam int unsigned SEG_W = 7;

    // Segment bit positions inside the 7-bit {g,f,e,d,c,b,a} vector
    localparam int unsigned SEG_BIT_A = 0;
    localparam int unsigned SEG_BIT_B = 1;
    localparam int unsigned SEG_BIT_C = 2;
    localparam int unsigned SEG_BIT_D = 3;
    localparam int unsigned SEG_BIT_E = 4;
    localparam int unsigned SEG_BIT_F = 5;
    localparam int unsigned SEG_BIT_G = 6;

    // High-true segment patterns indexed by hex value: 0-9, A, b, C, d, E, F
    localparam logic [15:0][SEG_W-1:0] SEG_TABLE = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    // Bits needed to hold 0..n-1 (at least one bit)
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 32'd1) ? $clog2(n) : 32'd1;
    endfunction

endpackage

// File: rtl/sev_seg_mux_if.sv
// Bus between the display source and the seven-segment scan driver.
// Ports: digits_i/dp_i/blank_i/blink_i/lz_en_i from the source (master);
//        seg_o/dp_o/an_o/frame_o from the driver (slave).
interface sev_seg_mux_if #(
    parameter int unsigned NUM_DIGITS = 8
);
    logic [4*NUM_DIGITS-1:0] digits_i;
    logic [NUM_DIGITS-1:0]   dp_i;
    logic [NUM_DIGITS-1:0]   blank_i;
    logic [NUM_DIGITS-1:0]   blink_i;
    logic                    lz_en_i;
    logic [6:0]              seg_o;
    logic                    dp_o;
    logic [NUM_DIGITS-1:0]   an_o;
    logic                    frame_o;

    modport master (
        output digits_i, dp_i, blank_i, blink_i, lz_en_i,
        input  seg_o, dp_o, an_o, frame_o
    );

    modport slave (
        input  digits_i, dp_i, blank_i, blink_i, lz_en_i,
        output seg_o, dp_o, an_o, frame_o
    );
endinterface

// File: rtl/sev_seg_decode.sv
// Combinational hex-to-seven-segment decoder, high-true, no polarity handling.
// Ports: hex (4-bit value in), seg_c (segments {g,f,e,d,c,b,a} out).
module sev_seg_decode
    import sev_seg_pkg::*;
(
    input  logic [3:0]       hex,
    output logic [SEG_W-1:0] seg_c
);
    logic [SEG_W-1:0] raw;

    assign raw = SEG_TABLE[hex];

    // Map table bits onto the {g,f,e,d,c,b,a} pin order
    assign seg_c = {raw[SEG_BIT_G], raw[SEG_BIT_F], raw[SEG_BIT_E], raw[SEG_BIT_D],
                    raw[SEG_BIT_C], raw[SEG_BIT_B], raw[SEG_BIT_A]};
endmodule

// File: rtl/sev_seg_mux.sv
// Time-multiplexed seven-segment driver with frame-latched inputs, blanking,
// blinking, leading-zero suppression, per-slot dead time and output polarity.
// Ports: clk, rst (async, active-high); bus (slave): digits_i, dp_i, blank_i,
//        blink_i, lz_en_i in; seg_o, dp_o, an_o (registered), frame_o out.
module sev_seg_mux
    import sev_seg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS   = 8,
    parameter int unsigned REFRESH_DIV  = 100000,
    parameter int unsigned DEAD_CYCLES  = 16,
    parameter int unsigned BLINK_FRAMES = 62,
    parameter int unsigned ACTIVE_LOW   = 1
) (
    input  logic         clk,
    input  logic         rst,
    sev_seg_mux_if.slave bus
);
    localparam int unsigned IDX_W = idx_width(NUM_DIGITS);
    localparam int unsigned CNT_W = idx_width(REFRESH_DIV);
    localparam int unsigned FRM_W = idx_width(BLINK_FRAMES);
    localparam logic        POL   = (ACTIVE_LOW != 0);

    logic [CNT_W-1:0]        cnt;
    logic [IDX_W-1:0]        idx;
    logic [FRM_W-1:0]        frm;
    logic                    phase;
    logic [4*NUM_DIGITS-1:0] snap_digits;
    logic [NUM_DIGITS-1:0]   snap_dp;
    logic [NUM_DIGITS-1:0]   snap_blank;
    logic [NUM_DIGITS-1:0]   snap_blink;
    logic                    snap_lz;

    logic                    tick;
    logic                    last;
    logic                    snap_en;
    logic                    lit;
    logic                    zero_run;
    logic [NUM_DIGITS-1:0]   lz_dark;
    logic [NUM_DIGITS-1:0]   dark;
    logic [NUM_DIGITS-1:0]   an_n;
    logic [3:0]              cur_hex;
    logic                    cur_dp;
    logic                    cur_dark;
    logic [SEG_W-1:0]        cur_seg;

    logic [SEG_W-1:0]        seg_q;
    logic                    dp_q;
    logic [NUM_DIGITS-1:0]   an_q;
    logic                    frame_q;

    assign tick    = (cnt == CNT_W'(REFRESH_DIV - 1));
    assign last    = (idx == IDX_W'(NUM_DIGITS - 1));
    assign snap_en = tick && last;

    // Slot prescaler and digit index
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            idx <= '0;
        end else if (tick) begin
            cnt <= '0;
            idx <= last ? '0 : idx + 1'b1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Frame snapshot; reset state keeps the first frame dark
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            snap_digits <= '0;
            snap_dp     <= '0;
            snap_blank  <= '1;
            snap_blink  <= '0;
            snap_lz     <= 1'b0;
        end else if (snap_en) begin
            snap_digits <= bus.digits_i;
            snap_dp     <= bus.dp_i;
            snap_blank  <= bus.blank_i;
            snap_blink  <= bus.blink_i;
            snap_lz     <= bus.lz_en_i;
        end
    end

    // Blink phase toggles only on snapshot edges
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frm   <= '0;
            phase <= 1'b0;
        end else if (snap_en) begin
            if (frm == FRM_W'(BLINK_FRAMES - 1)) begin
                frm   <= '0;
                phase <= ~phase;
            end else begin
                frm <= frm + 1'b1;
            end
        end
    end

    // Leading-zero mask: walk down from the top digit while digits stay zero
    always_comb begin
        zero_run = 1'b1;
        lz_dark  = '0;
        for (int d = NUM_DIGITS - 1; d >= 0; d--) begin
            zero_run   = zero_run && (snap_digits[4*d +: 4] == 4'h0);
            lz_dark[d] = snap_lz && zero_run && (d != 0);
        end
    end

    assign dark = snap_blank | (snap_blink & {NUM_DIGITS{phase}}) | lz_dark;

    // Select the current digit's fields and its one-hot anode
    always_comb begin
        cur_hex  = 4'h0;
        cur_dp   = 1'b0;
        cur_dark = 1'b1;
        an_n     = '0;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            if (idx == IDX_W'(d)) begin
                cur_hex  = snap_digits[4*d +: 4];
                cur_dp   = snap_dp[d];
                cur_dark = dark[d];
                an_n[d]  = 1'b1;
            end
        end
    end

    sev_seg_decode u_decode (
        .hex   (cur_hex),
        .seg_c (cur_seg)
    );

    assign lit = (cnt >= CNT_W'(DEAD_CYCLES)) && !cur_dark;

    // Output register with polarity folded in; frame_q is set one cycle
    // early so it is high in the same cycle the snapshot is taken
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an_q    <= {NUM_DIGITS{POL}};
            seg_q   <= {SEG_W{POL}};
            dp_q    <= POL;
            frame_q <= 1'b0;
        end else begin
            an_q    <= (lit ? an_n : '0) ^ {NUM_DIGITS{POL}};
            seg_q   <= (lit ? cur_seg : '0) ^ {SEG_W{POL}};
            dp_q    <= (lit && cur_dp) ^ POL;
            frame_q <= (cnt == CNT_W'(REFRESH_DIV - 2)) && last;
        end
    end

    assign bus.an_o    = an_q;
    assign bus.seg_o   = seg_q;
    assign bus.dp_o    = dp_q;
    assign bus.frame_o = frame_q;
endmodule
